// File: rtl/seq_pkg.sv
// Types and constants shared by bit_serializer and sequence_detector.
package seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam logic SEQ_IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: one word per WIDTH cycles, gapless back-to-back streaming.
// Optional word_done last-bit pulse is enabled by defining SERIALIZER_DONE_EN.
module bit_serializer
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter logic        IDLE_LEVEL = SEQ_IDLE_LEVEL
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             out_bit,
    output logic             out_valid
`ifdef SERIALIZER_DONE_EN
    ,
    output logic             word_done
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             out_bit_q, out_bit_d;
    logic             out_valid_q, out_valid_d;
    logic             accept;
    logic             last_bit;

    assign last_bit   = (bit_cnt_q == '0);
    assign word_ready = !clear && ((state_q == IDLE) || last_bit);
    assign accept     = word_valid && word_ready;
    assign out_bit    = out_bit_q;
    assign out_valid  = out_valid_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        out_bit_d   = out_bit_q;
        out_valid_d = out_valid_q;

        if (clear) begin
            state_d     = IDLE;
            shift_d     = '0;
            bit_cnt_d   = '0;
            out_bit_d   = IDLE_LEVEL;
            out_valid_d = 1'b0;
        end else if (accept) begin
            // The first bit goes straight to the output register; the shift
            // register keeps the whole word and advances from here.
            state_d     = SHIFT;
            shift_d     = word_in;
            bit_cnt_d   = CNT_W'(WIDTH - 1);
            out_bit_d   = MSB_FIRST ? word_in[WIDTH-1] : word_in[0];
            out_valid_d = 1'b1;
        end else if (state_q == SHIFT) begin
            if (last_bit) begin
                state_d     = IDLE;
                shift_d     = '0;
                out_bit_d   = IDLE_LEVEL;
                out_valid_d = 1'b0;
            end else begin
                bit_cnt_d = bit_cnt_q - CNT_W'(1);
                if (MSB_FIRST) begin
                    shift_d   = {shift_q[WIDTH-2:0], 1'b0};
                    out_bit_d = shift_q[WIDTH-2];
                end else begin
                    shift_d   = {1'b0, shift_q[WIDTH-1:1]};
                    out_bit_d = shift_q[1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            out_bit_q   <= IDLE_LEVEL;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef SERIALIZER_DONE_EN
    logic word_done_q, word_done_d;

    // Counter at 1 means the next cycle carries the last bit; no accept can
    // happen at that edge because word_ready is low.
    assign word_done_d = !clear && (state_q == SHIFT) && (bit_cnt_q == CNT_W'(1));
    assign word_done   = word_done_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_done_q <= 1'b0;
        end else begin
            word_done_q <= word_done_d;
        end
    end
`endif

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: MSB-first instance and an LSB-first, idle-high instance.
module tb_bit_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       clear_a, valid_a, ready_a, out_bit_a, out_valid_a, done_a;
    logic [3:0] word_a;
    logic       clear_b, valid_b, ready_b, out_bit_b, out_valid_b;
    logic [3:0] word_b;

    int errors = 0;
    int checks = 0;

    bit_serializer #(
        .WIDTH      (4),
        .MSB_FIRST  (1'b1),
        .IDLE_LEVEL (1'b0)
    ) u_dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear_a),
        .word_in    (word_a),
        .word_valid (valid_a),
        .word_ready (ready_a),
        .out_bit    (out_bit_a),
        .out_valid  (out_valid_a)
`ifdef SERIALIZER_DONE_EN
        ,
        .word_done  (done_a)
`endif
    );

`ifndef SERIALIZER_DONE_EN
    assign done_a = 1'b0;
`endif

    bit_serializer #(
        .WIDTH      (4),
        .MSB_FIRST  (1'b0),
        .IDLE_LEVEL (1'b1)
    ) u_dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear_b),
        .word_in    (word_b),
        .word_valid (valid_b),
        .word_ready (ready_b),
        .out_bit    (out_bit_b),
        .out_valid  (out_valid_b)
`ifdef SERIALIZER_DONE_EN
        ,
        .word_done  ()
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_done(input string tag, input logic exp);
`ifdef SERIALIZER_DONE_EN
        chk(tag, 32'(done_a), 32'(exp));
`endif
    endtask

    // Called in cycle N+1 after an accept; leaves the bench in cycle N+5.
    task automatic expect_word_a(input string tag, input logic [3:0] w);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_bit%0d", tag, i), 32'(out_bit_a), 32'(w[3-i]));
            chk($sformatf("%s_vld%0d", tag, i), 32'(out_valid_a), 32'd1);
            chk($sformatf("%s_rdy%0d", tag, i), 32'(ready_a), 32'(i == 3));
            chk_done($sformatf("%s_done%0d", tag, i), (i == 3));
            step();
        end
        chk({tag, "_idle_vld"}, 32'(out_valid_a), 32'd0);
        chk({tag, "_idle_bit"}, 32'(out_bit_a), 32'd0);
        chk({tag, "_idle_rdy"}, 32'(ready_a), 32'd1);
        chk_done({tag, "_idle_done"}, 1'b0);
    endtask

    initial begin
        logic [7:0] stream_exp;
        logic       bits [8];
        int         hits;

        reset_n = 1'b0;
        clear_a = 1'b0; valid_a = 1'b0; word_a = '0;
        clear_b = 1'b0; valid_b = 1'b0; word_b = '0;
        #12;
        chk("rst_bit_a", 32'(out_bit_a), 32'd0);
        chk("rst_vld_a", 32'(out_valid_a), 32'd0);
        chk("rst_rdy_a", 32'(ready_a), 32'd1);
        chk_done("rst_done_a", 1'b0);
        chk("rst_bit_b", 32'(out_bit_b), 32'd1);
        chk("rst_vld_b", 32'(out_valid_b), 32'd0);
        reset_n = 1'b1;
        step();

        // Single MSB-first word
        word_a = 4'b1011; valid_a = 1'b1;
        chk("t1_rdy_pre", 32'(ready_a), 32'd1);
        step();
        valid_a = 1'b0;
        expect_word_a("t1", 4'b1011);

        // Back-to-back words with valid held
        stream_exp = 8'b1011_0110;
        word_a = 4'b1011; valid_a = 1'b1;
        step();
        word_a = 4'b0110;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) valid_a = 1'b0;
            chk($sformatf("t2_bit%0d", i), 32'(out_bit_a), 32'(stream_exp[7-i]));
            chk($sformatf("t2_vld%0d", i), 32'(out_valid_a), 32'd1);
            if (i == 3) chk("t2_rdy_last", 32'(ready_a), 32'd1);
            chk_done($sformatf("t2_done%0d", i), (i == 3 || i == 7));
            bits[i] = out_bit_a;
            step();
        end
        chk("t2_idle_vld", 32'(out_valid_a), 32'd0);
        hits = 0;
        for (int j = 0; j < 5; j++) begin
            if (bits[j] && !bits[j+1] && bits[j+2] && bits[j+3]) hits++;
        end
        chk("t2_pattern_hits", 32'(hits), 32'd2);

        // Clear after two bits; a pending word must not sneak in during clear
        word_a = 4'b1011; valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        chk("t3_bit0", 32'(out_bit_a), 32'd1);
        step();
        chk("t3_bit1", 32'(out_bit_a), 32'd0);
        clear_a = 1'b1; word_a = 4'b0110; valid_a = 1'b1;
        #1;
        chk("t3_rdy_clr", 32'(ready_a), 32'd0);
        step();
        clear_a = 1'b0;
        #1;
        chk("t3_vld_after", 32'(out_valid_a), 32'd0);
        chk("t3_bit_after", 32'(out_bit_a), 32'd0);
        chk("t3_rdy_after", 32'(ready_a), 32'd1);
        chk_done("t3_done_after", 1'b0);
        step();
        valid_a = 1'b0;
        expect_word_a("t3", 4'b0110);

        // Asynchronous reset mid-word
        word_a = 4'b1011; valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("t4_rst_vld", 32'(out_valid_a), 32'd0);
        chk("t4_rst_bit", 32'(out_bit_a), 32'd0);
        chk("t4_rst_rdy", 32'(ready_a), 32'd1);
        chk_done("t4_rst_done", 1'b0);
        #1;
        reset_n = 1'b1;
        step();
        chk("t4_no_partial", 32'(out_valid_a), 32'd0);
        word_a = 4'b1011; valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        expect_word_a("t4", 4'b1011);

        // LSB-first instance with idle level high
        word_b = 4'b1101; valid_b = 1'b1;
        step();
        valid_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t5_bit%0d", i), 32'(out_bit_b), 32'(i != 1));
            chk($sformatf("t5_vld%0d", i), 32'(out_valid_b), 32'd1);
            step();
        end
        chk("t5_idle_bit", 32'(out_bit_b), 32'd1);
        chk("t5_idle_vld", 32'(out_valid_b), 32'd0);
        chk("t5_idle_rdy", 32'(ready_b), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Upstream feeder for `sequence_detector`: accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on `out_bit`, which drives the detector's `in_bit` directly. Back-to-back words stream with no idle bit between them, so patterns that span word boundaries reach the detector intact. Between words, the line holds a programmable idle level.

## Interface
- `WIDTH`, default 8: word width in bits. Must be ≥ 2.
- `MSB_FIRST`, default 1: 1 shifts bit `WIDTH-1` first; 0 shifts bit 0 first.
- `IDLE_LEVEL`, default 0: value driven on `out_bit` while no word is shifting.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous abort of the current word.
- `word_in` in `WIDTH`: parallel word.
- `word_valid` in 1: `word_in` is valid.
- `word_ready` out 1: block accepts `word_in` at this edge if `word_valid` is high.
- `out_bit` out 1: serial data, registered. Connects to the detector's `in_bit`.
- `out_valid` out 1: `out_bit` carries a word bit (not idle fill).
- `word_done` out 1: present only with `SERIALIZER_DONE_EN`; see Configuration.

## Operation
- FSM states: `IDLE` and `SHIFT`.
  - `IDLE` → `SHIFT` on accept (`word_valid && word_ready`).
  - `SHIFT` → `IDLE` after the last bit, unless a new word is accepted on that same edge.
  - `SHIFT` → `IDLE` on `clear`.
- Accept loads a `WIDTH`-bit shift register and sets `bit_cnt` to `WIDTH-1`.
  - Each `SHIFT` cycle presents one bit and decrements `bit_cnt`.
  - `bit_cnt` is `$clog2(WIDTH)` bits wide and never wraps below 0.
- `word_ready` is combinational from state only, never from `word_valid`:
  - High in `IDLE`.
  - High in `SHIFT` when `bit_cnt == 0` (last bit).
  - Forced low whenever `clear` = 1.
- Accept on the last bit reloads the shift register, so the next word's first bit follows the previous word's last bit with no gap.
- `clear` takes priority over accept and over shifting. The next cycle shows `out_bit = IDLE_LEVEL`, `out_valid = 0`, state `IDLE`. The partially shifted word is discarded.
- Bit order follows `MSB_FIRST`, fixed at elaboration.
- Reset values: state `IDLE`, `out_bit = IDLE_LEVEL`, `out_valid = 0`, `word_ready = 1` (from `IDLE`), `word_done = 0`, shift register 0, `bit_cnt` 0.
- Reset mid-word discards the word immediately (asynchronous). There is no partial output after `reset_n` deasserts.

## Timing
- An accept at edge N drives the first bit on `out_bit` and `out_valid` in cycle N+1.
- Bit k (0-based, in shift order) appears in cycle N+1+k. The last bit appears in cycle N+`WIDTH`.
- Throughput is one word per `WIDTH` cycles when `word_valid` stays asserted.
- `out_valid` is high for exactly `WIDTH` consecutive cycles per accepted word, uninterrupted across back-to-back words.
- `clear` asserted at edge M: `out_valid = 0` from cycle M+1 onward.

## Configuration
- Macro `SERIALIZER_DONE_EN`.
- Defined: adds the `word_done` output port. `word_done` is a one-cycle registered pulse, coincident with the cycle that carries each word's last bit on `out_bit`. It is not pulsed for words aborted by `clear` or reset.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `seq_pkg` holds:
  - the `ser_state_t` enum (`IDLE`, `SHIFT`), shared with the detector's state typedef style;
  - the localparam `SEQ_IDLE_LEVEL` = 0, used as the default for `IDLE_LEVEL`.
- Single module; no sub-module is warranted. The shift register and counter are trivially inline.

## Test plan
- `WIDTH=4`, `MSB_FIRST=1`, accept `4'b1011` at edge N:
  - `out_bit` = 1,0,1,1 in cycles N+1..N+4, `out_valid` high for those 4 cycles;
  - the downstream detector asserts `detected` once.
- Back-to-back `4'b1011` then `4'b0110` with `word_valid` held:
  - second word accepted on the last-bit cycle;
  - 8 contiguous valid bits 1,0,1,1,0,1,1,0;
  - the detector fires twice, the second time on the overlapping pattern across the boundary.
- `MSB_FIRST=0`, word `4'b1101` → `out_bit` = 1,0,1,1.
- `clear` asserted after 2 bits of `4'b1011`:
  - next cycle `out_valid = 0`, `out_bit = 0`;
  - `word_ready` is 0 during `clear` and 1 in the following cycle;
  - the next word starts cleanly.
- `reset_n` pulled low mid-word (asynchronous, between edges):
  - all outputs go immediately to reset values;
  - after release, a fresh `4'b1011` serializes correctly.
- With `SERIALIZER_DONE_EN`:
  - `word_done` pulses once per word, aligned to the last bit;
  - no pulse for a word aborted by `clear`.
